// File: rtl/bsg_id_pool_rr_alloc.sv
// bsg_id_pool_rr_alloc: shared ID pool with per-requester caps, round-robin grant and owner-tracked dealloc
// clk_i/reset_i: clock, async active-high reset
// req_v_i/grant_o/grant_id_o: per-requester requests, one-hot grant and the ID handed out
// dealloc_v_i/dealloc_id_i: ID return; credit goes back to the recorded owner
// outstanding_o: per-requester held counts (requester 0 in LSBs); empty_o/full_o: pool state; err_o: sticky illegal-dealloc flag
module bsg_id_pool_rr_alloc #(
  parameter int els_p = 4,
  parameter int num_req_p = 3,
  parameter int max_outstanding_p = els_p,
  parameter int id_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int req_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  parameter int cnt_width_lp = $clog2(max_outstanding_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              grant_o,
  output logic [id_width_lp-1:0]            grant_id_o,
  input  logic                              dealloc_v_i,
  input  logic [id_width_lp-1:0]            dealloc_id_i,
  output logic [num_req_p*cnt_width_lp-1:0] outstanding_o,
  output logic                              empty_o,
  output logic                              full_o,
  output logic                              err_o
);
  localparam logic [cnt_width_lp-1:0] cap_lp = cnt_width_lp'(max_outstanding_p);
  logic [els_p-1:0] r_alloc;
  logic [req_width_lp-1:0] r_owner [els_p];
  logic [cnt_width_lp-1:0] r_cnt [num_req_p];
  logic [req_width_lp-1:0] r_rr;
  logic r_err;
  logic [num_req_p-1:0] w_elig, w_dec;
  logic [id_width_lp-1:0] w_free;
  logic [req_width_lp-1:0] w_win;
  logic w_gv, w_grant, w_dlegal;
  int w_best, w_dist;
  always_comb begin
    w_free = '0;
    for (int i = els_p - 1; i >= 0; i--) w_free = r_alloc[i] ? w_free : id_width_lp'(i);
  end
  // winner is the eligible requester with the smallest circular distance from the pointer
  always_comb begin
    w_elig = '0;
    w_gv = 1'b0;
    w_win = '0;
    w_best = num_req_p;
    w_dist = 0;
    for (int i = 0; i < num_req_p; i++) begin
      w_elig[i] = req_v_i[i] & (r_cnt[i] < cap_lp);
      w_dist = (i >= int'(r_rr)) ? i - int'(r_rr) : i + num_req_p - int'(r_rr);
      if (w_elig[i] && w_dist < w_best) begin
        w_best = w_dist;
        w_win = req_width_lp'(i);
        w_gv = 1'b1;
      end
    end
  end
  assign w_grant = w_gv & ~full_o & ~reset_i;
  assign grant_o = w_grant ? (num_req_p'(1) << w_win) : '0;
  assign grant_id_o = reset_i ? '0 : w_free;
  assign w_dlegal = dealloc_v_i && (int'(dealloc_id_i) < els_p) && r_alloc[dealloc_id_i];
  assign w_dec = w_dlegal ? (num_req_p'(1) << r_owner[dealloc_id_i]) : '0;
  assign full_o = &r_alloc;
  assign empty_o = ~|r_alloc;
  assign err_o = r_err;
  for (genvar g = 0; g < num_req_p; g++) begin : g_out
    assign outstanding_o[g*cnt_width_lp +: cnt_width_lp] = r_cnt[g];
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_alloc <= '0;
      r_rr <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < num_req_p; i++) r_cnt[i] <= '0;
      for (int i = 0; i < els_p; i++) r_owner[i] <= '0;
    end else begin
      if (w_grant) begin
        r_alloc[w_free] <= 1'b1;
        r_owner[w_free] <= w_win;
        r_rr <= (int'(w_win) == num_req_p - 1) ? '0 : w_win + 1'b1;
      end
      if (w_dlegal) r_alloc[dealloc_id_i] <= 1'b0;
      if (dealloc_v_i && !w_dlegal) r_err <= 1'b1;
      // a grant and a return on the same requester cancel out
      for (int i = 0; i < num_req_p; i++)
        if (grant_o[i] != w_dec[i]) r_cnt[i] <= grant_o[i] ? r_cnt[i] + 1'b1 : r_cnt[i] - 1'b1;
    end
  end
`ifndef SYNTHESIS
  int w_sum;
  always_comb begin
    w_sum = 0;
    for (int i = 0; i < num_req_p; i++) w_sum += int'(r_cnt[i]);
  end
  always @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < num_req_p; i++) assert (r_cnt[i] <= cap_lp);
      assert (w_sum == $countones(r_alloc));
      assert ($onehot0(grant_o));
    end
  end
`endif
endmodule

// File: tb/tb_bsg_id_pool_rr_alloc.sv
// tb_bsg_id_pool_rr_alloc: directed and randomized checks of the ID pool against a behavioural model
module tb_bsg_id_pool_rr_alloc;
  localparam int E = 4, N = 3, M = 2, IW = 2, CW = 2;
  logic clk_i = 1'b0, reset_i = 1'b1, dealloc_v_i = 1'b0;
  logic [N-1:0] req_v_i = '0, grant_o;
  logic [IW-1:0] grant_id_o, dealloc_id_i = '0;
  logic [N*CW-1:0] outstanding_o;
  logic empty_o, full_o, err_o;
  int n_chk = 0, n_fail = 0;
  bit m_alloc [E];
  int m_owner [E];
  int m_cnt [N];
  int m_rr;
  bit m_err;
  bsg_id_pool_rr_alloc #(.els_p(E), .num_req_p(N), .max_outstanding_p(M)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_v_i(req_v_i), .grant_o(grant_o),
    .grant_id_o(grant_id_o), .dealloc_v_i(dealloc_v_i), .dealloc_id_i(dealloc_id_i),
    .outstanding_o(outstanding_o), .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void decide(input logic [N-1:0] req, input bit rst, output bit gv, output int w, output int id);
    bit full;
    full = 1'b1;
    gv = 1'b0;
    w = 0;
    id = 0;
    for (int i = E - 1; i >= 0; i--) if (!m_alloc[i]) id = i;
    for (int i = 0; i < E; i++) full = full & m_alloc[i];
    if (!full && !rst)
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_rr + k) % N;
        if (!gv && req[r] && m_cnt[r] < M) begin
          gv = 1'b1;
          w = r;
        end
      end
  endfunction
  always @(posedge clk_i or posedge reset_i) begin
    bit ugv;
    int uw, uid;
    if (reset_i) begin
      for (int i = 0; i < E; i++) m_alloc[i] = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0;
      m_err = 1'b0;
    end else begin
      decide(req_v_i, 1'b0, ugv, uw, uid);
      if (dealloc_v_i) begin
        if (m_alloc[dealloc_id_i]) begin
          m_alloc[dealloc_id_i] = 1'b0;
          m_cnt[m_owner[dealloc_id_i]]--;
        end else m_err = 1'b1;
      end
      if (ugv) begin
        m_alloc[uid] = 1'b1;
        m_owner[uid] = uw;
        m_cnt[uw]++;
        m_rr = (uw + 1) % N;
      end
    end
  end
  always @(negedge clk_i) begin
    bit cgv;
    int cw, cid, na;
    logic [N*CW-1:0] eo;
    decide(req_v_i, reset_i, cgv, cw, cid);
    eo = '0;
    na = 0;
    for (int i = 0; i < N; i++) eo |= (N*CW)'(m_cnt[i]) << (CW * i);
    for (int i = 0; i < E; i++) na += int'(m_alloc[i]);
    chk("grant", 32'(grant_o), cgv ? 32'(1 << cw) : 32'd0);
    if (cgv) chk("grant_id", 32'(grant_id_o), 32'(cid));
    chk("empty", 32'(empty_o), 32'(na == 0));
    chk("full", 32'(full_o), 32'(na == E));
    chk("err", 32'(err_o), 32'(m_err));
    chk("outstanding", 32'(outstanding_o), 32'(eo));
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    req_v_i = '0;
    dealloc_v_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask
  task automatic expect_g(input logic [N-1:0] g, input logic [IW-1:0] id);
    #1;
    chk("lit_grant", 32'(grant_o), 32'(g));
    if (g != '0) chk("lit_id", 32'(grant_id_o), 32'(id));
  endtask
  initial begin
    do_reset();
    req_v_i = 3'b111;
    expect_g(3'b001, 2'd0); tick();
    expect_g(3'b010, 2'd1); tick();
    expect_g(3'b100, 2'd2); tick();
    expect_g(3'b001, 2'd3); tick();
    expect_g(3'b000, 2'd0);
    chk("t1_full", 32'(full_o), 32'd1);
    chk("t1_outst", 32'(outstanding_o), 32'(6'b01_01_10));
    req_v_i = 3'b010;
    dealloc_v_i = 1'b1;
    dealloc_id_i = 2'd2;
    expect_g(3'b000, 2'd0); tick();
    dealloc_v_i = 1'b0;
    expect_g(3'b010, 2'd2);
    chk("t3_outst_a", 32'(outstanding_o), 32'(6'b00_01_10));
    tick();
    req_v_i = '0;
    #1 chk("t3_outst_b", 32'(outstanding_o), 32'(6'b00_10_10));
    do_reset();
    req_v_i = 3'b001;
    expect_g(3'b001, 2'd0); tick();
    expect_g(3'b001, 2'd1); tick();
    expect_g(3'b000, 2'd0);
    chk("t2_full", 32'(full_o), 32'd0);
    dealloc_v_i = 1'b1;
    dealloc_id_i = 2'd0;
    expect_g(3'b000, 2'd0); tick();
    dealloc_v_i = 1'b0;
    expect_g(3'b001, 2'd0); tick();
    do_reset();
    req_v_i = 3'b011;
    expect_g(3'b001, 2'd0); tick();
    expect_g(3'b010, 2'd1); tick();
    req_v_i = '0;
    dealloc_v_i = 1'b1;
    dealloc_id_i = 2'd0;
    tick();
    dealloc_id_i = 2'd3;
    #1 chk("t4_err_before", 32'(err_o), 32'd0);
    tick();
    dealloc_v_i = 1'b0;
    #1 chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_outst", 32'(outstanding_o), 32'(6'b00_01_00));
    chk("t4_empty", 32'(empty_o), 32'd0);
    tick();
    #1 chk("t4_err_sticky", 32'(err_o), 32'd1);
    req_v_i = 3'b100;
    expect_g(3'b100, 2'd0); tick();
    req_v_i = '0;
    #1 chk("t4_outst_after", 32'(outstanding_o), 32'(6'b01_01_00));
    do_reset();
    req_v_i = 3'b100;
    expect_g(3'b100, 2'd0); tick();
    req_v_i = 3'b001;
    expect_g(3'b001, 2'd1); tick();
    req_v_i = 3'b101;
    expect_g(3'b100, 2'd2); tick();
    expect_g(3'b001, 2'd3); tick();
    do_reset();
    req_v_i = 3'b111;
    tick();
    tick();
    dealloc_v_i = 1'b1;
    dealloc_id_i = 2'd3;
    tick();
    dealloc_v_i = 1'b0;
    #1 chk("t6_err_set", 32'(err_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("t6_grant", 32'(grant_o), 32'd0);
    chk("t6_empty", 32'(empty_o), 32'd1);
    chk("t6_err", 32'(err_o), 32'd0);
    chk("t6_outst", 32'(outstanding_o), 32'd0);
    tick();
    #2 reset_i = 1'b0;
    expect_g(3'b001, 2'd0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      int s;
      bit found;
      s = $urandom_range(0, E - 1);
      found = 1'b0;
      dealloc_id_i = IW'(s);
      if ($urandom_range(0, 9) != 0)
        for (int k = 0; k < E; k++)
          if (!found && m_alloc[(s + k) % E]) begin
            found = 1'b1;
            dealloc_id_i = IW'((s + k) % E);
          end
      req_v_i = N'($urandom_range(0, 7));
      dealloc_v_i = ($urandom_range(0, 2) == 0);
      reset_i = (c == 1500);
      tick();
    end
    reset_i = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
